mem_port_arbiter: RTL and testbench

- Shares the single memory/IO path between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Sits between the core and memory_io_mux and drives its rd_mem_*/wr_mem_* inputs.
- Issues at most one transaction per cycle and returns read data with a response pulse to the owning requester.
- The synchronous RAM behind the mux has a 1-cycle read latency.

---
 rtl/constants_pkg.sv | 17 +
 rtl/mem_port_arbiter_rsp_pipe.sv | 29 ++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/constants_pkg.sv
// Shared widths and memory-arbiter types for the core's memory path.
package constants_pkg;

  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS    = 8;
  localparam int MEM_ARB_STATS_WIDTH = 16;

  typedef enum logic {OWNER_IF, OWNER_LS} mem_owner_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [MEM_ARB_STATS_WIDTH-1:0] sat_inc(
    input logic [MEM_ARB_STATS_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rsp_pipe.sv
// Response tracking: {valid, owner} shift register matching the memory read latency.
module mem_rsp_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] owner_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      owner_reg <= '0;
    end else begin
      valid_reg <= (valid_reg << 1) | DEPTH'(in_valid);
      owner_reg <= (owner_reg << 1) | DEPTH'(in_owner);
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_owner = owner_reg[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of memory_io_mux.
// Define MEM_ARB_STATS_EN to add saturating grant/conflict counters.
module mem_port_arbiter
  import constants_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           if_req,
  input  logic [MEMORY_ADDRESS_BITS-1:0] if_addr,
  output logic                           if_gnt,
  output logic                           if_rsp_valid,
  input  logic                           ls_req,
  input  logic                           ls_we,
  input  logic [MEMORY_ADDRESS_BITS-1:0] ls_addr,
  input  logic [MEMORY_DATA_BITS-1:0]    ls_wdata,
  output logic                           ls_gnt,
  output logic                           ls_rsp_valid,
  output logic [MEMORY_DATA_BITS-1:0]    rsp_data,
  output logic                           rd_mem_en,
  output logic [MEMORY_ADDRESS_BITS-1:0] rd_mem_addr,
  input  logic [MEMORY_DATA_BITS-1:0]    rd_mem_data,
  output logic                           wr_mem_en,
  output logic [MEMORY_ADDRESS_BITS-1:0] wr_mem_addr,
  output logic [MEMORY_DATA_BITS-1:0]    wr_mem_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [MEM_ARB_STATS_WIDTH-1:0] if_grant_cnt,
  output logic [MEM_ARB_STATS_WIDTH-1:0] ls_grant_cnt,
  output logic [MEM_ARB_STATS_WIDTH-1:0] conflict_cnt
`endif
);

  mem_owner_t last_owner_reg;
  mem_owner_t issue_owner_reg;
  logic       pipe_valid;
  logic       pipe_owner_ls;

  // Round-robin on ties: the side that did not win last time goes first.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset) begin
      if (if_req && (!ls_req || last_owner_reg == OWNER_LS)) begin
        if_gnt = 1'b1;
      end else if (ls_req) begin
        ls_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_mem_en       <= 1'b0;
      rd_mem_addr     <= '0;
      wr_mem_en       <= 1'b0;
      wr_mem_addr     <= '0;
      wr_mem_data     <= '0;
      last_owner_reg  <= OWNER_LS;
      issue_owner_reg <= OWNER_IF;
    end else begin
      rd_mem_en <= if_gnt || (ls_gnt && !ls_we);
      wr_mem_en <= ls_gnt && ls_we;
      if (if_gnt) begin
        rd_mem_addr     <= if_addr;
        issue_owner_reg <= OWNER_IF;
        last_owner_reg  <= OWNER_IF;
      end else if (ls_gnt) begin
        last_owner_reg <= OWNER_LS;
        if (ls_we) begin
          wr_mem_addr <= ls_addr;
          wr_mem_data <= ls_wdata;
        end else begin
          rd_mem_addr     <= ls_addr;
          issue_owner_reg <= OWNER_LS;
        end
      end
    end
  end

  // The tag enters alongside the issued strobe, so it emerges with the data.
  mem_rsp_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rsp_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_mem_en),
    .in_owner (issue_owner_reg == OWNER_LS),
    .out_valid(pipe_valid),
    .out_owner(pipe_owner_ls)
  );

  assign if_rsp_valid = pipe_valid && !pipe_owner_ls;
  assign ls_rsp_valid = pipe_valid && pipe_owner_ls;
  assign rsp_data     = rd_mem_data;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_grant_cnt <= '0;
      ls_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (if_gnt) if_grant_cnt <= sat_inc(if_grant_cnt);
      if (ls_gnt) ls_grant_cnt <= sat_inc(ls_grant_cnt);
      if (if_req && ls_req) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, random traffic, mid-flight reset.
module tb_mem_port_arbiter;
  import constants_pkg::*;

  localparam int L = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       if_req = 1'b0;
  logic [7:0] if_addr = '0;
  logic       if_gnt, if_rsp_valid;
  logic       ls_req = 1'b0;
  logic       ls_we = 1'b0;
  logic [7:0] ls_addr = '0;
  logic [7:0] ls_wdata = '0;
  logic       ls_gnt, ls_rsp_valid;
  logic [7:0] rsp_data;
  logic       rd_mem_en;
  logic [7:0] rd_mem_addr;
  logic [7:0] rd_mem_data = '0;
  logic       wr_mem_en;
  logic [7:0] wr_mem_addr, wr_mem_data;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] if_grant_cnt, ls_grant_cnt, conflict_cnt;
  int m_if_cnt, m_ls_cnt, m_conf_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rsp_valid(if_rsp_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rsp_valid(ls_rsp_valid), .rsp_data(rsp_data),
    .rd_mem_en(rd_mem_en), .rd_mem_addr(rd_mem_addr), .rd_mem_data(rd_mem_data),
    .wr_mem_en(wr_mem_en), .wr_mem_addr(wr_mem_addr), .wr_mem_data(wr_mem_data)
`ifdef MEM_ARB_STATS_EN
    , .if_grant_cnt(if_grant_cnt), .ls_grant_cnt(ls_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  // Synchronous RAM stand-in with 1-cycle read latency
  function automatic logic [7:0] init_byte(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : 8'(a * 8'd7 + 8'd3);
  endfunction

  logic       ram_load = 1'b0;
  logic [7:0] ram [256];
  always_ff @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_byte(8'(i));
    end else if (wr_mem_en) begin
      ram[wr_mem_addr] <= wr_mem_data;
    end
    if (rd_mem_en) rd_mem_data <= ram[rd_mem_addr];
  end

  // Reference model: expected grants from the tie rule, responses queued in grant order
  typedef struct {
    int         due;
    logic       owner_ls;
    logic [7:0] data;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [7:0] shadow [256];
  logic       m_last_ls;
  logic       m_rd_en, m_wr_en;
  logic [7:0] m_rd_addr, m_wr_addr, m_wr_data;
  int         cyc;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    rsp_q.delete();
    m_last_ls = 1'b1;
    m_rd_en   = 1'b0;
    m_wr_en   = 1'b0;
    cyc       = 0;
`ifdef MEM_ARB_STATS_EN
    m_if_cnt = 0; m_ls_cnt = 0; m_conf_cnt = 0;
`endif
  endtask

  task automatic check_idle_outputs();
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    check("rst_rd_en", 32'(rd_mem_en), 32'd0);
    check("rst_wr_en", 32'(wr_mem_en), 32'd0);
    check("rst_rd_addr", 32'(rd_mem_addr), 32'd0);
    check("rst_wr_addr", 32'(wr_mem_addr), 32'd0);
    check("rst_wr_data", 32'(wr_mem_data), 32'd0);
    check("rst_if_rsp", 32'(if_rsp_valid), 32'd0);
    check("rst_ls_rsp", 32'(ls_rsp_valid), 32'd0);
`ifdef MEM_ARB_STATS_EN
    check("rst_if_cnt", 32'(if_grant_cnt), 32'd0);
    check("rst_ls_cnt", 32'(ls_grant_cnt), 32'd0);
    check("rst_conf_cnt", 32'(conflict_cnt), 32'd0);
`endif
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic run_cycle(input logic ir, input logic [7:0] ia, input logic lr, input logic lw,
                           input logic [7:0] la, input logic [7:0] lwd,
                           output logic g_if, output logic g_ls);
    logic e_if, e_ls, rsp_v, rsp_ls;
    logic [7:0] rsp_d;
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = lwd;
    @(negedge clk);
    e_if = ir && (!lr || m_last_ls);
    e_ls = lr && !e_if;
    g_if = if_gnt;
    g_ls = ls_gnt;
    check("if_gnt", 32'(if_gnt), 32'(e_if));
    check("ls_gnt", 32'(ls_gnt), 32'(e_ls));
    check("rd_mem_en", 32'(rd_mem_en), 32'(m_rd_en));
    if (m_rd_en) check("rd_mem_addr", 32'(rd_mem_addr), 32'(m_rd_addr));
    check("wr_mem_en", 32'(wr_mem_en), 32'(m_wr_en));
    if (m_wr_en) begin
      check("wr_mem_addr", 32'(wr_mem_addr), 32'(m_wr_addr));
      check("wr_mem_data", 32'(wr_mem_data), 32'(m_wr_data));
    end
    rsp_v = 1'b0; rsp_ls = 1'b0; rsp_d = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      rsp_v  = 1'b1;
      rsp_ls = rsp_q[0].owner_ls;
      rsp_d  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(rsp_v && !rsp_ls));
    check("ls_rsp_valid", 32'(ls_rsp_valid), 32'(rsp_v && rsp_ls));
    if (rsp_v) check("rsp_data", 32'(rsp_data), 32'(rsp_d));
`ifdef MEM_ARB_STATS_EN
    check("if_grant_cnt", 32'(if_grant_cnt), 32'(m_if_cnt));
    check("ls_grant_cnt", 32'(ls_grant_cnt), 32'(m_ls_cnt));
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf_cnt));
    if (e_if && m_if_cnt < 65535) m_if_cnt++;
    if (e_ls && m_ls_cnt < 65535) m_ls_cnt++;
    if (ir && lr && m_conf_cnt < 65535) m_conf_cnt++;
`endif
    m_rd_en = e_if || (e_ls && !lw);
    m_wr_en = e_ls && lw;
    if (e_if) begin
      m_last_ls = 1'b0;
      m_rd_addr = ia;
      rsp_q.push_back('{cyc + 1 + L, 1'b0, shadow[ia]});
    end else if (e_ls) begin
      m_last_ls = 1'b1;
      if (lw) begin
        m_wr_addr = la; m_wr_data = lwd; shadow[la] = lwd;
      end else begin
        m_rd_addr = la;
        rsp_q.push_back('{cyc + 1 + L, 1'b1, shadow[la]});
      end
    end
    $display("cyc %0d req if=%0b ls=%0b we=%0b gnt if=%0b ls=%0b rsp if=%0b ls=%0b data=%02h",
             cyc, ir, lr, lw, g_if, g_ls, if_rsp_valid, ls_rsp_valid, rsp_data);
    @(posedge clk); #1;
    cyc++;
  endtask

  typedef struct {
    logic ir; logic [7:0] ia; logic lr; logic lw; logic [7:0] la; logic [7:0] lwd;
    logic eg_if; logic eg_ls;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [7:0] ia, input logic lr, input logic lw,
                              input logic [7:0] la, input logic [7:0] lwd,
                              input logic eg_if, input logic eg_ls);
    vec_t v;
    v.ir = ir; v.ia = ia; v.lr = lr; v.lw = lw; v.la = la; v.lwd = lwd;
    v.eg_if = eg_if; v.eg_ls = eg_ls;
    return v;
  endfunction

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic g_if, g_ls;
    logic ir, lr, lw;
    logic [7:0] ia, la, lwd;

    for (int i = 0; i < 256; i++) shadow[i] = init_byte(8'(i));

    // Tie at release -> IF; single read; IO store; 4-cycle contention; back-to-back; read-back of store
    vecs[0]  = mk(1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hFD, 8'h3C, 1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 8'h20, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0);
    vecs[11] = mk(1'b1, 8'h20, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1);
    vecs[12] = mk(1'b1, 8'h20, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0);
    vecs[13] = mk(1'b1, 8'h20, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1);
    vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1);
    vecs[15] = mk(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    vecs[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[18] = mk(1'b1, 8'hFD, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    vecs[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset held with both requests high
    reset = 1'b1; ram_load = 1'b1;
    if_req = 1'b1; if_addr = 8'h10; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h30;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs();
      $display("reset cycle %0d gnt if=%0b ls=%0b rd_en=%0b wr_en=%0b", i, if_gnt, ls_gnt, rd_mem_en, wr_mem_en);
    end
    @(posedge clk); #1;
    ram_load = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_cycle(vecs[i].ir, vecs[i].ia, vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].lwd, g_if, g_ls);
      check("tbl_if_gnt", 32'(g_if), 32'(vecs[i].eg_if));
      check("tbl_ls_gnt", 32'(g_ls), 32'(vecs[i].eg_ls));
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      ir  = 1'($urandom_range(0, 1));
      lr  = 1'($urandom_range(0, 1));
      lw  = 1'($urandom_range(0, 1));
      ia  = 8'($urandom_range(0, 255));
      la  = 8'($urandom_range(0, 255));
      lwd = 8'($urandom_range(0, 255));
      run_cycle(ir, ia, lr, lw, la, lwd, g_if, g_ls);
    end
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, g_if, g_ls);

    // Mid-flight reset: IF read granted, reset pulsed during the issue cycle
    run_cycle(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00, g_if, g_ls);
    if_req = 1'b0; ls_req = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_idle_outputs();
    $display("mid-flight reset asserted rd_en=%0b if_rsp=%0b", rd_mem_en, if_rsp_valid);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, g_if, g_ls);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
